// File: rtl/if_fetch_queue_pkg.sv
// Purpose: shared widths, reset PC and bus payload layouts for the IF front end.
package if_fetch_queue_pkg;

  localparam int unsigned IF_TO_ID_BUS_W   = 65;
  localparam int unsigned BR_BUS_W         = 33;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c00_0000;

  // IF -> ID payload: {inst, pc, adef}
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        adef;
  } if_to_id_t;

  // ID -> IF branch payload: {br_valid, br_target}
  typedef struct packed {
    logic        valid;
    logic [31:0] target;
  } br_bus_t;

endpackage

// File: rtl/if_fetch_queue_fifo.sv
// Purpose: synchronous FIFO with flush, full/empty flags and occupancy count.
// Ports:
//   clk, resetn   clock, async active-low reset
//   flush         drop all entries (wins over push/pop)
//   push, din     write request and data (ignored when full unless popping)
//   pop, dout     read request (ignored when empty) and head data
//   full, empty   occupancy flags
//   count         number of stored entries
module fq_sync_fifo #(
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         flush,
  input  logic                         push,
  input  logic [W-1:0]                 din,
  input  logic                         pop,
  output logic [W-1:0]                 dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // Storage needs no reset; consumers qualify dout with empty.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers and count.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/if_fetch_queue.sv
// Purpose: pre-IF + IF front end. Issues pipelined instruction fetches on the
// SRAM-like req/addr_ok/data_ok bus, tags each request with its PC, buffers
// returned instructions for ID and cancels in-flight responses on redirect.
// Ports:
//   clk, resetn                 clock, async active-low reset
//   id_allow                    ID consumes the head entry this cycle
//   if_to_id_valid/_bus         head entry {inst, pc, adef}
//   branch_bus, id_br_stall     branch {valid, target}; taken when not stalled
//   wb_exception, ex_entry      exception flush and entry PC
//   ertn_flush, ertn_entry      ertn flush and return PC
//   inst_sram_*                 instruction SRAM request/response bus
module if_fetch_queue
  import if_fetch_queue_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned IBUF_DEPTH      = 4,
  parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      id_allow,
  output logic                      if_to_id_valid,
  output logic [IF_TO_ID_BUS_W-1:0] if_to_id_bus,
  input  logic [BR_BUS_W-1:0]       branch_bus,
  input  logic                      id_br_stall,
  input  logic                      wb_exception,
  input  logic [31:0]               ex_entry,
  input  logic                      ertn_flush,
  input  logic [31:0]               ertn_entry,
  output logic                      inst_sram_req,
  output logic                      inst_sram_wr,
  output logic [1:0]                inst_sram_size,
  output logic [3:0]                inst_sram_wstrb,
  output logic [31:0]               inst_sram_addr,
  output logic [31:0]               inst_sram_wdata,
  input  logic                      inst_sram_addr_ok,
  input  logic                      inst_sram_data_ok,
  input  logic [31:0]               inst_sram_rdata
);

  localparam int unsigned PW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned QW = $clog2(IBUF_DEPTH + 1);
  localparam int unsigned SW = ((PW > QW) ? PW : QW) + 1;

  br_bus_t     br;
  logic        taken;
  logic        redirect;
  logic [31:0] redirect_pc;

  logic        run;
  logic        halt;
  logic [31:0] fetch_pc;
  logic        fetch_adef;
  logic [PW-1:0] pend_cnt;
  logic [PW-1:0] cancel_cnt;
  logic [SW-1:0] credit_used;

  logic        accept;
  logic        resp_keep;
  logic        adef_push;

  logic [31:0]   tag_pc;
  logic          tag_full;
  logic          tag_empty;
  logic [PW-1:0] tag_count;

  if_to_id_t   q_din;
  if_to_id_t   q_dout;
  logic        q_push;
  logic        q_pop;
  logic        q_full;
  logic        q_empty;
  logic [QW-1:0] q_count;

  assign br       = branch_bus;
  assign taken    = br.valid & ~id_br_stall;
  assign redirect = wb_exception | ertn_flush | taken;

  // Redirect target: exception over ertn over branch.
  always_comb begin
    redirect_pc = br.target;
    if (wb_exception) begin
      redirect_pc = ex_entry;
    end else if (ertn_flush) begin
      redirect_pc = ertn_entry;
    end
  end

  assign fetch_adef = (fetch_pc[1:0] != 2'b00);

  // Live in-flight responses plus queued entries must leave a free slot.
  assign credit_used = SW'(pend_cnt - cancel_cnt) + SW'(q_count);

  assign inst_sram_req = run & ~redirect & ~halt & ~fetch_adef
                       & (pend_cnt < PW'(MAX_OUTSTANDING))
                       & (credit_used < SW'(IBUF_DEPTH));
  assign inst_sram_addr  = fetch_pc;
  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'd2;
  assign inst_sram_wstrb = 4'd0;
  assign inst_sram_wdata = 32'd0;

  assign accept    = inst_sram_req & inst_sram_addr_ok;
  assign resp_keep = inst_sram_data_ok & ~redirect & (cancel_cnt == '0);
  // Misaligned PC: report once after all older responses have drained.
  assign adef_push = run & fetch_adef & ~redirect & ~halt
                   & (pend_cnt == '0) & (q_count < QW'(IBUF_DEPTH));

  always_comb begin
    q_din = '0;
    if (resp_keep) begin
      q_din.inst = inst_sram_rdata;
      q_din.pc   = tag_pc;
    end else begin
      q_din.pc   = fetch_pc;
      q_din.adef = 1'b1;
    end
  end

  assign q_push         = resp_keep | adef_push;
  assign if_to_id_valid = ~q_empty & ~redirect;
  assign q_pop          = if_to_id_valid & id_allow;
  assign if_to_id_bus   = q_empty ? '0 : q_dout;

  // Fetch PC, halt and request bookkeeping.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      run        <= 1'b0;
      halt       <= 1'b0;
      fetch_pc   <= RESET_PC;
      pend_cnt   <= '0;
      cancel_cnt <= '0;
    end else begin
      run      <= 1'b1;
      pend_cnt <= pend_cnt + PW'(accept) - PW'(inst_sram_data_ok);
      if (redirect) begin
        fetch_pc   <= redirect_pc;
        halt       <= 1'b0;
        cancel_cnt <= pend_cnt - PW'(inst_sram_data_ok);
      end else begin
        if (accept)    fetch_pc <= fetch_pc + 32'd4;
        if (adef_push) halt     <= 1'b1;
        if (inst_sram_data_ok && (cancel_cnt != '0)) begin
          cancel_cnt <= cancel_cnt - PW'(1);
        end
      end
    end
  end

  // PC tags of accepted requests, matched to in-order responses.
  fq_sync_fifo #(.W(32), .DEPTH(MAX_OUTSTANDING)) u_tag_fifo (
    .clk    (clk),
    .resetn (resetn),
    .flush  (1'b0),
    .push   (accept),
    .din    (fetch_pc),
    .pop    (inst_sram_data_ok),
    .dout   (tag_pc),
    .full   (tag_full),
    .empty  (tag_empty),
    .count  (tag_count)
  );

  // Instruction queue feeding ID.
  fq_sync_fifo #(.W(IF_TO_ID_BUS_W), .DEPTH(IBUF_DEPTH)) u_inst_queue (
    .clk    (clk),
    .resetn (resetn),
    .flush  (redirect),
    .push   (q_push),
    .din    (q_din),
    .pop    (q_pop),
    .dout   (q_dout),
    .full   (q_full),
    .empty  (q_empty),
    .count  (q_count)
  );

  a_pend_underflow: assert property (@(posedge clk) disable iff (!resetn)
    !(inst_sram_data_ok && (pend_cnt == '0)));
  a_tag_empty: assert property (@(posedge clk) disable iff (!resetn)
    !(inst_sram_data_ok && tag_empty));
  a_tag_full: assert property (@(posedge clk) disable iff (!resetn)
    !(accept && tag_full));
  a_tag_count: assert property (@(posedge clk) disable iff (!resetn)
    tag_count == pend_cnt);
  a_cancel_le_pend: assert property (@(posedge clk) disable iff (!resetn)
    cancel_cnt <= pend_cnt);
  a_queue_overflow: assert property (@(posedge clk) disable iff (!resetn)
    !(q_push && q_full && !q_pop && !redirect));

endmodule

// File: tb/tb_if_fetch_queue.sv
module tb_if_fetch_queue;

  localparam logic [31:0] RST_PC = 32'h1c00_0000;

  logic        clk = 1'b0;
  logic        resetn;
  logic        id_allow;
  logic        if_to_id_valid;
  logic [64:0] if_to_id_bus;
  logic [32:0] branch_bus;
  logic        id_br_stall;
  logic        wb_exception;
  logic [31:0] ex_entry;
  logic        ertn_flush;
  logic [31:0] ertn_entry;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;

  int n_checks = 0;
  int n_pass   = 0;
  int budget   = 0;
  bit resp_hold = 1'b0;
  logic [31:0] pend_q[$];
  logic [31:0] acc_log[$];
  logic [64:0] exp_q[$];

  if_fetch_queue dut (
    .clk               (clk),
    .resetn            (resetn),
    .id_allow          (id_allow),
    .if_to_id_valid    (if_to_id_valid),
    .if_to_id_bus      (if_to_id_bus),
    .branch_bus        (branch_bus),
    .id_br_stall       (id_br_stall),
    .wb_exception      (wb_exception),
    .ex_entry          (ex_entry),
    .ertn_flush        (ertn_flush),
    .ertn_entry        (ertn_entry),
    .inst_sram_req     (inst_sram_req),
    .inst_sram_wr      (inst_sram_wr),
    .inst_sram_size    (inst_sram_size),
    .inst_sram_wstrb   (inst_sram_wstrb),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_wdata   (inst_sram_wdata),
    .inst_sram_addr_ok (inst_sram_addr_ok),
    .inst_sram_data_ok (inst_sram_data_ok),
    .inst_sram_rdata   (inst_sram_rdata)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h5a5a_f00f;
  endfunction

  task automatic chk(input string name, input logic [64:0] got, input logic [64:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic exp_push(input logic [31:0] pc);
    exp_q.push_back({inst_of(pc), pc, 1'b0});
  endtask

  task automatic exp_run(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) exp_push(base + 32'(4 * i));
  endtask

  task automatic wait_accepts(input string name, input int n);
    int t;
    t = 0;
    while (acc_log.size() < n && t < 50) begin
      tick();
      t++;
    end
    chk(name, 65'(acc_log.size()), 65'(n));
  endtask

  task automatic wait_drain(input string name, output int cycles);
    cycles = 0;
    while ((exp_q.size() != 0 || pend_q.size() != 0 || budget != 0) && cycles < 200) begin
      tick();
      cycles++;
    end
    chk(name, 65'(exp_q.size() + pend_q.size() + budget), 65'(0));
  endtask

  task automatic check_accepts(input string name, input logic [31:0] base, input int n);
    chk({name, "_count"}, 65'(acc_log.size()), 65'(n));
    for (int i = 0; i < n && i < acc_log.size(); i++) begin
      chk(name, 65'(acc_log[i]), 65'(base + 32'(4 * i)));
    end
    acc_log.delete();
  endtask

  // SRAM model: grants while budget lasts, answers one cycle after each accept.
  initial begin
    inst_sram_addr_ok = 1'b0;
    inst_sram_data_ok = 1'b0;
    inst_sram_rdata   = '0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        pend_q.delete();
        inst_sram_data_ok = 1'b0;
        inst_sram_addr_ok = 1'b0;
      end else begin
        if (!resp_hold && pend_q.size() > 0) begin
          inst_sram_data_ok = 1'b1;
          inst_sram_rdata   = inst_of(pend_q.pop_front());
        end else begin
          inst_sram_data_ok = 1'b0;
          inst_sram_rdata   = '0;
        end
        inst_sram_addr_ok = (budget > 0);
      end
      #2;
      if (resetn && inst_sram_req && inst_sram_addr_ok) begin
        pend_q.push_back(inst_sram_addr);
        acc_log.push_back(inst_sram_addr);
        budget--;
      end
    end
  end

  // Monitor: every ID handshake must match the next expected entry.
  initial begin
    logic [64:0] e;
    forever begin
      @(negedge clk);
      #3;
      if (resetn && if_to_id_valid && id_allow) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL id_unexpected: got %h expected no entry", if_to_id_bus);
        end else begin
          e = exp_q.pop_front();
          chk("id_entry", if_to_id_bus, e);
        end
      end
    end
  end

  initial begin
    int cyc;
    resetn = 1'b0; id_allow = 1'b1; branch_bus = '0; id_br_stall = 1'b0;
    wb_exception = 1'b0; ex_entry = '0; ertn_flush = 1'b0; ertn_entry = '0;
    tick(); tick();

    // 1: reset state, then streaming
    chk("rst_req", 65'(inst_sram_req), 65'(0));
    chk("rst_valid", 65'(if_to_id_valid), 65'(0));
    chk("rst_bus", if_to_id_bus, 65'(0));
    chk("tie_size", 65'(inst_sram_size), 65'(2));
    chk("tie_wr_wstrb_wdata", 65'({inst_sram_wr, inst_sram_wstrb, inst_sram_wdata}), 65'(0));
    resetn = 1'b1;
    budget = 6;
    exp_run(RST_PC, 6);
    wait_drain("t1_drain", cyc);
    chk("t1_rate", 65'(cyc <= 12), 65'(1));
    check_accepts("t1_addr", RST_PC, 6);

    // 2: ID stalled fills exactly IBUF_DEPTH entries
    id_allow = 1'b0;
    budget = 10;
    exp_run(32'h1c00_0018, 10);
    repeat (12) tick();
    chk("t2_accepts", 65'(acc_log.size()), 65'(4));
    chk("t2_req_off", 65'(inst_sram_req), 65'(0));
    chk("t2_valid", 65'(if_to_id_valid), 65'(1));
    chk("t2_head", if_to_id_bus, exp_q[0]);
    branch_bus = {1'b1, 32'h1c00_0300};
    id_br_stall = 1'b1;
    #1;
    chk("t2_stalled_br_valid", 65'(if_to_id_valid), 65'(1));
    tick();
    branch_bus = '0;
    id_br_stall = 1'b0;
    tick();
    chk("t2_stalled_br_head", if_to_id_bus, exp_q[0]);
    id_allow = 1'b1;
    wait_drain("t2_drain", cyc);
    check_accepts("t2_addr", 32'h1c00_0018, 10);

    // 3: taken branch with two requests in flight
    resp_hold = 1'b1;
    budget = 2;
    wait_accepts("t3_inflight", 2);
    check_accepts("t3_pre", 32'h1c00_0040, 2);
    branch_bus = {1'b1, 32'h1c00_0100};
    #1;
    chk("t3_req_redirect", 65'(inst_sram_req), 65'(0));
    tick();
    branch_bus = '0;
    resp_hold = 1'b0;
    budget = 3;
    exp_run(32'h1c00_0100, 3);
    wait_drain("t3_drain", cyc);
    check_accepts("t3_addr", 32'h1c00_0100, 3);

    // 4: all redirect sources together with a data_ok
    resp_hold = 1'b1;
    budget = 2;
    wait_accepts("t4_inflight", 2);
    check_accepts("t4_pre", 32'h1c00_010c, 2);
    resp_hold = 1'b0;
    tick();
    wb_exception = 1'b1; ex_entry = 32'h1c00_0400;
    ertn_flush = 1'b1; ertn_entry = 32'h1c00_0500;
    branch_bus = {1'b1, 32'h1c00_0600};
    #1;
    chk("t4_req_redirect", 65'(inst_sram_req), 65'(0));
    chk("t4_valid_redirect", 65'(if_to_id_valid), 65'(0));
    tick();
    wb_exception = 1'b0; ertn_flush = 1'b0; branch_bus = '0;
    budget = 2;
    exp_run(32'h1c00_0400, 2);
    wait_drain("t4_drain", cyc);
    check_accepts("t4_addr", 32'h1c00_0400, 2);

    // 5: misaligned branch target raises ADEF and halts until ertn
    branch_bus = {1'b1, 32'h1c00_0102};
    #1;
    chk("t5_req_redirect", 65'(inst_sram_req), 65'(0));
    tick();
    branch_bus = '0;
    budget = 3;
    exp_q.push_back({32'd0, 32'h1c00_0102, 1'b1});
    repeat (8) tick();
    chk("t5_no_accept", 65'(acc_log.size()), 65'(0));
    chk("t5_halt_req", 65'(inst_sram_req), 65'(0));
    chk("t5_adef_seen", 65'(exp_q.size()), 65'(0));
    ertn_flush = 1'b1;
    ertn_entry = 32'h1c00_0200;
    #1;
    chk("t5_req_ertn", 65'(inst_sram_req), 65'(0));
    tick();
    ertn_flush = 1'b0;
    exp_run(32'h1c00_0200, 3);
    wait_drain("t5_drain", cyc);
    check_accepts("t5_addr", 32'h1c00_0200, 3);

    // 6: reset mid-stream with a queued entry and two in flight
    id_allow = 1'b0;
    budget = 1;
    wait_accepts("t6_first", 1);
    tick(); tick();
    resp_hold = 1'b1;
    budget = 2;
    wait_accepts("t6_inflight", 3);
    check_accepts("t6_pre", 32'h1c00_020c, 3);
    chk("t6_pre_valid", 65'(if_to_id_valid), 65'(1));
    resetn = 1'b0;
    budget = 0;
    #1;
    chk("t6_rst_req", 65'(inst_sram_req), 65'(0));
    chk("t6_rst_valid", 65'(if_to_id_valid), 65'(0));
    chk("t6_rst_bus", if_to_id_bus, 65'(0));
    tick(); tick();
    resp_hold = 1'b0;
    id_allow = 1'b1;
    resetn = 1'b1;
    budget = 2;
    exp_run(RST_PC, 2);
    wait_drain("t6_drain", cyc);
    check_accepts("t6_addr", RST_PC, 2);

    tick(); tick();
    chk("end_scoreboard_empty", 65'(exp_q.size()), 65'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
